// File: rtl/twofish_round_ctrl_pkg.sv
// Shared types and constants for the Twofish round controller.
package twofish_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IN    = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam int DEF_ROUNDS = 16;

    // Subkey bases: K0..3 and K4..7 are the whitening words, round keys start at K8.
    localparam int KW_IN   = 0;
    localparam int KW_OUT  = 4;
    localparam int KR_BASE = 8;

endpackage

// File: rtl/twofish_round_ctrl_if.sv
// Host-side handshake plus datapath strobes of the Twofish round controller.
interface twofish_round_ctrl_if #(
    parameter int CNT_W  = 5,
    parameter int KIDX_W = 6
);
    logic              start;
    logic              decrypt;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  round;
    logic [KIDX_W-1:0] key_idx;
    logic              IW0;
    logic              IW1;
    logic              OW0;
    logic              OW1;
    logic              M;
    logic              DM;

    modport master (
        output start, decrypt,
        input  busy, done, round, key_idx, IW0, IW1, OW0, OW1, M, DM
    );

    modport slave (
        input  start, decrypt,
        output busy, done, round, key_idx, IW0, IW1, OW0, OW1, M, DM
    );
endinterface

// File: rtl/twofish_round_ctrl_decode.sv
// Combinational map from (state, phase, mode) to strobes, round number and subkey index.
module twofish_ctrl_decode
    import twofish_pkg::*;
#(
    parameter int ROUNDS = DEF_ROUNDS,
    parameter int CNT_W  = 5,
    parameter int KIDX_W = 6
) (
    input  state_t            st,
    input  logic [CNT_W-1:0]  ph,
    input  logic              mode,
    output logic              iw0,
    output logic              iw1,
    output logic              ow0,
    output logic              ow1,
    output logic              m,
    output logic              dm,
    output logic              done,
    output logic [CNT_W-1:0]  rnd,
    output logic [KIDX_W-1:0] key_idx
);
    logic [CNT_W-1:0]  rnd_c;
    logic [KIDX_W-1:0] two_r;

    // Decode one phase; decrypt walks the round-key pairs from the top down.
    always_comb begin
        iw0     = 1'b0;
        iw1     = 1'b0;
        ow0     = 1'b0;
        ow1     = 1'b0;
        m       = 1'b0;
        dm      = 1'b0;
        done    = 1'b0;
        rnd     = '0;
        key_idx = '0;
        rnd_c   = ph - CNT_W'(2);
        two_r   = KIDX_W'(rnd_c) << 1;
        case (st)
            IN: begin
                iw0     = (ph == CNT_W'(0));
                iw1     = (ph == CNT_W'(1));
                key_idx = mode ? KIDX_W'(KW_OUT) : KIDX_W'(KW_IN);
            end
            ROUND: begin
                rnd     = rnd_c;
                m       = (rnd_c != '0);
                dm      = mode;
                key_idx = mode ? (KIDX_W'(KR_BASE + 2 * (ROUNDS - 1)) - two_r)
                               : (KIDX_W'(KR_BASE) + two_r);
            end
            OUT: begin
                ow0     = (ph == CNT_W'(ROUNDS + 2));
                ow1     = (ph == CNT_W'(ROUNDS + 3));
                done    = (ph == CNT_W'(ROUNDS + 3));
                key_idx = mode ? KIDX_W'(KW_IN) : KIDX_W'(KW_OUT);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/twofish_round_ctrl.sv
// Twofish block controller: phase counter, start/done handshake and registered datapath strobes.
// Optional feature: define TWOFISH_CTRL_ABORT_EN to add an `abort` input that drops a block.
module twofish_round_ctrl
    import twofish_pkg::*;
#(
    parameter int ROUNDS = DEF_ROUNDS,
    parameter int CNT_W  = 5,
    parameter int KIDX_W = 6
) (
    input logic clk,
    input logic rst,
`ifdef TWOFISH_CTRL_ABORT_EN
    input logic abort,
`endif
    twofish_round_ctrl_if.slave bus
);
    state_t            state_q, state_nx;
    logic [CNT_W-1:0]  ph_q, ph_nx;
    logic              mode_q, mode_nx;

    logic              iw0_d, iw1_d, ow0_d, ow1_d, m_d, dm_d, done_d;
    logic [CNT_W-1:0]  rnd_d;
    logic [KIDX_W-1:0] key_d;

    logic              iw0_q, iw1_q, ow0_q, ow1_q, m_q, dm_q, done_q, busy_q;
    logic [CNT_W-1:0]  rnd_q;
    logic [KIDX_W-1:0] key_q;

    // Next state and phase; the phase restarts at 0 on every return to IDLE so it never wraps.
    always_comb begin
        state_nx = state_q;
        ph_nx    = ph_q;
        mode_nx  = mode_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_nx = IN;
                    ph_nx    = '0;
                    mode_nx  = bus.decrypt;
                end
            end
            IN: begin
                ph_nx = ph_q + CNT_W'(1);
                if (ph_q == CNT_W'(1)) state_nx = ROUND;
            end
            ROUND: begin
                ph_nx = ph_q + CNT_W'(1);
                if (ph_q == CNT_W'(ROUNDS + 1)) state_nx = OUT;
            end
            OUT: begin
                if (ph_q == CNT_W'(ROUNDS + 3)) begin
                    state_nx = IDLE;
                    ph_nx    = '0;
                end else begin
                    ph_nx = ph_q + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                ph_nx    = '0;
            end
        endcase
`ifdef TWOFISH_CTRL_ABORT_EN
        if (abort && (state_q != IDLE)) begin
            state_nx = IDLE;
            ph_nx    = '0;
        end
`endif
    end

    // Strobes are decoded from the next state so they appear registered in the cycle they belong to.
    twofish_ctrl_decode #(
        .ROUNDS (ROUNDS),
        .CNT_W  (CNT_W),
        .KIDX_W (KIDX_W)
    ) u_decode (
        .st      (state_nx),
        .ph      (ph_nx),
        .mode    (mode_nx),
        .iw0     (iw0_d),
        .iw1     (iw1_d),
        .ow0     (ow0_d),
        .ow1     (ow1_d),
        .m       (m_d),
        .dm      (dm_d),
        .done    (done_d),
        .rnd     (rnd_d),
        .key_idx (key_d)
    );

    // State, phase, latched mode and all outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ph_q    <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            iw0_q   <= 1'b0;
            iw1_q   <= 1'b0;
            ow0_q   <= 1'b0;
            ow1_q   <= 1'b0;
            m_q     <= 1'b0;
            dm_q    <= 1'b0;
            done_q  <= 1'b0;
            rnd_q   <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_nx;
            ph_q    <= ph_nx;
            mode_q  <= mode_nx;
            busy_q  <= (state_nx != IDLE);
            iw0_q   <= iw0_d;
            iw1_q   <= iw1_d;
            ow0_q   <= ow0_d;
            ow1_q   <= ow1_d;
            m_q     <= m_d;
            dm_q    <= dm_d;
            done_q  <= done_d;
            rnd_q   <= rnd_d;
            key_q   <= key_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.round   = rnd_q;
    assign bus.key_idx = key_q;
    assign bus.IW0     = iw0_q;
    assign bus.IW1     = iw1_q;
    assign bus.OW0     = ow0_q;
    assign bus.OW1     = ow1_q;
    assign bus.M       = m_q;
    assign bus.DM      = dm_q;
endmodule

// File: doc/twofish_round_ctrl.md
# twofish_round_ctrl

Sequential, parametrised controller for the Twofish encrypt/decrypt datapath. It owns its own phase counter and start/done handshake, and drives the per-cycle datapath strobes `IW0`, `IW1`, `OW0`, `OW1`, `M` and `DM` for one block. It also generates round and subkey indices, with the subkey order reversed for decryption. It sits between the block-level host interface and the round datapath/key schedule RAM.

## Interface
- `ROUNDS`, 16: number of Feistel rounds; legal range 2..16.
- `CNT_W`, 5: phase counter width; must hold `ROUNDS+3`.
- `KIDX_W`, 6: subkey index width; covers K0..K(8+2·ROUNDS−1).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to process one block; sampled only in IDLE.
- `decrypt`  in  1  mode; sampled with an accepted `start`, held internally for the whole block.
- `busy`  out  1  high from the cycle after acceptance through the `done` cycle.
- `done`  out  1  one-cycle pulse, coincident with `OW1`.
- `round`  out  CNT_W  current round number 0..ROUNDS−1; 0 outside ROUND.
- `key_idx`  out  KIDX_W  index of the first subkey of the pair/quad in use.
- `IW0`, `IW1`  out  1  input-whitening load strobes, low and high half.
- `OW0`, `OW1`  out  1  output-whitening/store strobes, low and high half.
- `M`  out  1  round-input mux: 0 selects whitened input, 1 selects feedback.
- `DM`  out  1  decrypt-mode select to the datapath; equals latched `decrypt` during ROUND.

## Operation
- States: IDLE → IN → ROUND → OUT → IDLE. The phase counter `ph` runs 0..ROUNDS+3 inside a block.
- **IDLE**: all outputs 0. `start=1` latches `decrypt`, clears `ph` and moves to IN.
- **IN** (2 cycles):
  - `ph=0`: `IW0=1`.
  - `ph=1`: `IW1=1`.
  - `key_idx`: 0 for encrypt, 4 for decrypt (input whitening K0..3 or K4..7).
- **ROUND** (ROUNDS cycles), `round=ph−2`:
  - `M=0` when `round=0`, otherwise `M=1`.
  - `DM` = latched `decrypt`.
  - `key_idx`: `8+2·round` for encrypt, `8+2·(ROUNDS−1−round)` for decrypt.
- **OUT** (2 cycles):
  - `ph=ROUNDS+2`: `OW0=1`.
  - `ph=ROUNDS+3`: `OW1=1`, `done=1`.
  - `key_idx`: 4 for encrypt, 0 for decrypt.
  - Next state is IDLE.
- Strobes are mutually exclusive and are registered outputs (no combinational path from `start`).
- `start` while busy is ignored and not queued.
- A `start` in the IDLE cycle immediately following `done` is accepted, so back-to-back blocks are possible.
- `decrypt` changes mid-block have no effect.
- Counter arithmetic is unsigned. `ph` never exceeds `ROUNDS+3` and never wraps.

## Timing
- `start` accepted at edge t:
  - `IW0` at cycle t+1, `IW1` at t+2.
  - Rounds at t+3..t+2+ROUNDS.
  - `OW0` at t+3+ROUNDS.
  - `OW1` and `done` at t+4+ROUNDS.
- Total latency is ROUNDS+4 cycles; 20 cycles for ROUNDS=16.
- Throughput: one block per ROUNDS+5 cycles including the IDLE gap.
- `rst` at any point, including mid-block: the next edge forces IDLE, `ph=0`, latched mode 0, and every output 0. No `done` is produced for the aborted block.
- `rst` and `start` high together: reset wins.

## Configuration
- `TWOFISH_CTRL_ABORT_EN` defined:
  - Adds input port `abort` (1 bit).
  - `abort=1` in any non-IDLE state returns to IDLE at the next edge with all outputs 0 and no `done`.
  - `abort` in IDLE has no effect.
  - `abort` and `start` together in IDLE: `start` is accepted.
- Macro undefined: no `abort` port; a block always runs to completion unless `rst` is asserted.

## Structure
- Package `twofish_pkg` holds:
  - the state enum (IDLE, IN, ROUND, OUT);
  - default `ROUNDS`;
  - whitening base constants `KW_IN=0`, `KW_OUT=4`, `KR_BASE=8`.
- Sub-module `twofish_ctrl_decode`: combinational map from (state, `ph`, mode) to the next values of the strobes and `key_idx`. Its outputs are registered in `twofish_round_ctrl`.

## Test plan
- Encrypt, ROUNDS=16: `start` at t → `IW0`@t+1, `IW1`@t+2, `round` 0..15 over t+3..t+18, `key_idx` 8,10..38, `M=0` only @t+3, `OW0`@t+19, `OW1`+`done`@t+20, `key_idx`=4 in OUT.
- Decrypt, ROUNDS=16: `key_idx`=4 in IN, then 38,36..8 in ROUND, `DM=1` throughout ROUND, `key_idx`=0 in OUT; toggling `decrypt` mid-block changes nothing.
- Back-to-back: `start` held high → second `IW0` exactly 2 cycles after the first `done`; pulses on `start` while busy are ignored.
- Reset mid-block: `rst` at t+10 → at t+11 all outputs are 0 and `busy=0`; no `done` ever appears; a new `start` then runs a full 20-cycle block.
- ROUNDS=2: `done` at t+6; `key_idx` encrypt 8,10; decrypt 10,8.
- With `TWOFISH_CTRL_ABORT_EN`: `abort` at t+5 → IDLE at t+6 with no `done`; `abort`+`start` together in IDLE → block starts normally.
